// File: rtl/multi_ch_freq_div.sv
// Multi-channel programmable clock divider: square, duty or one-shot waveform per channel with period tick.
// Shadow config is written through a shared port and only becomes active at a period boundary.
module multi_ch_freq_div #(
   parameter int         CH         = 4,
   parameter int         WIDTH      = 32,
   parameter int         DEF_PERIOD = 2,
   parameter int         DEF_HIGH   = 1,
   parameter logic [1:0] DEF_MODE   = 2'd0,
   localparam int        CHW        = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH-1:0]    ch_en,
   input  logic             wr_en,
   input  logic [CHW-1:0]   wr_ch,
   input  logic [WIDTH-1:0] wr_period,
   input  logic [WIDTH-1:0] wr_high,
   input  logic [1:0]       wr_mode,
   output logic             wr_err,
   output logic [CH-1:0]    div_out,
   output logic [CH-1:0]    tick,
   output logic [CH-1:0]    done
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

   localparam logic [CHW:0]   CH_L  = (CHW+1)'(CH);
   localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_PERIOD);
   localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEF_HIGH);

   // ceil(P/2) as (P>>1)+P[0] so P=2^WIDTH-1 cannot overflow
   function automatic logic [WIDTH-1:0] f_heff(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] h,
                                               input logic [1:0]       m);
      if (m == 2'd0) f_heff = (p >> 1) + {{(WIDTH-1){1'b0}}, p[0]};
      else           f_heff = (h < p) ? h : p;
   endfunction

   logic w_wr_ok;
   logic r_wr_err;

   assign w_wr_ok = wr_en && (wr_period != '0) && (wr_mode != 2'd3) && ({1'b0, wr_ch} < CH_L);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_wr_err <= 1'b0;
      else      r_wr_err <= wr_en && !w_wr_ok;
   end

   assign wr_err = r_wr_err;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      state_t           r_state, w_nxt_state;
      logic [WIDTH-1:0] r_sh_per, r_sh_high, r_act_per, r_act_high, r_cnt, w_nxt_cnt;
      logic [1:0]       r_sh_mode, r_act_mode;
      logic [WIDTH-1:0] w_sh_heff, w_act_heff;
      logic             r_div, r_tick, r_done;
      logic             w_nxt_div, w_nxt_tick, w_nxt_done, w_load, w_sel;

      assign w_sel      = w_wr_ok && ({1'b0, wr_ch} == (CHW+1)'(i));
      assign w_sh_heff  = f_heff(r_sh_per, r_sh_high, r_sh_mode);
      assign w_act_heff = f_heff(r_act_per, r_act_high, r_act_mode);

      always_comb begin
         w_nxt_state = r_state;
         w_nxt_cnt   = r_cnt;
         w_load      = 1'b0;
         w_nxt_div   = 1'b0;
         w_nxt_tick  = 1'b0;
         w_nxt_done  = 1'b0;
         if (!ch_en[i]) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
         end else begin
            case (r_state)
               ST_IDLE: w_load = 1'b1;
               ST_RUN: begin
                  if (r_cnt != '0) begin
                     w_nxt_cnt = r_cnt - 1'b1;
                     w_nxt_div = (r_act_per - r_cnt) < w_act_heff;
                  end else if (r_act_mode == 2'd2) begin
                     w_nxt_state = ST_DONE;
                     w_nxt_done  = 1'b1;
                  end else begin
                     w_load = 1'b1;
                  end
               end
               ST_DONE: w_nxt_done = 1'b1;
               default: w_nxt_state = ST_IDLE;
            endcase
         end
         // start and reload share one path: the period's phase 0 comes from the shadow
         if (w_load) begin
            w_nxt_state = ST_RUN;
            w_nxt_cnt   = r_sh_per - 1'b1;
            w_nxt_tick  = 1'b1;
            w_nxt_div   = (w_sh_heff != '0);
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_div      <= 1'b0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
            r_sh_per   <= DEF_P;
            r_sh_high  <= DEF_H;
            r_sh_mode  <= DEF_MODE;
            r_act_per  <= DEF_P;
            r_act_high <= DEF_H;
            r_act_mode <= DEF_MODE;
         end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_div   <= w_nxt_div;
            r_tick  <= w_nxt_tick;
            r_done  <= w_nxt_done;
            if (w_load) begin
               r_act_per  <= r_sh_per;
               r_act_high <= r_sh_high;
               r_act_mode <= r_sh_mode;
            end
            if (w_sel) begin
               r_sh_per  <= wr_period;
               r_sh_high <= wr_high;
               r_sh_mode <= wr_mode;
            end
         end
      end

      assign div_out[i] = r_div;
      assign tick[i]    = r_tick;
      assign done[i]    = r_done;
   end

endmodule

// File: tb/tb_multi_ch_freq_div.sv
// Bench for multi_ch_freq_div: directed scenarios plus random traffic against a phase-based reference model.
module tb_multi_ch_freq_div;
   localparam int CH = 3;
   localparam int W  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [CH-1:0] ch_en = '0;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_ch = '0;
   logic [W-1:0]  wr_period = '0;
   logic [W-1:0]  wr_high = '0;
   logic [1:0]    wr_mode = '0;
   logic          wr_err;
   logic [CH-1:0] div_out, tick, done;

   multi_ch_freq_div #(.CH(CH), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .ch_en(ch_en), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_period(wr_period), .wr_high(wr_high), .wr_mode(wr_mode),
      .wr_err(wr_err), .div_out(div_out), .tick(tick), .done(done));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Model: 0=idle 1=running 2=finished; phase counts up from 0 within a period
   int m_st[CH], m_ph[CH], m_ap[CH], m_ah[CH], m_am[CH], m_sp[CH], m_sh[CH], m_sm[CH];
   bit m_div[CH], m_tick[CH], m_done[CH];
   bit m_err;

   function automatic int heff(input int p, input int h, input int m);
      if (m == 0) return (p + 1) / 2;
      return (h < p) ? h : p;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_st[c] = 0; m_ph[c] = 0;
         m_ap[c] = 2; m_ah[c] = 1; m_am[c] = 0;
         m_sp[c] = 2; m_sh[c] = 1; m_sm[c] = 0;
         m_div[c] = 0; m_tick[c] = 0; m_done[c] = 0;
      end
      m_err = 0;
   endtask

   task automatic model_start(input int c);
      m_ap[c] = m_sp[c]; m_ah[c] = m_sh[c]; m_am[c] = m_sm[c];
      m_st[c] = 1; m_ph[c] = 0;
      m_tick[c] = 1; m_div[c] = heff(m_ap[c], m_ah[c], m_am[c]) > 0; m_done[c] = 0;
   endtask

   task automatic model_clock();
      bit ok;
      for (int c = 0; c < CH; c++) begin
         m_tick[c] = 0; m_div[c] = 0; m_done[c] = 0;
         if (!ch_en[c]) begin
            m_st[c] = 0;
         end else if (m_st[c] == 0) begin
            model_start(c);
         end else if (m_st[c] == 1) begin
            if (m_ph[c] + 1 < m_ap[c]) begin
               m_ph[c]++;
               m_div[c] = m_ph[c] < heff(m_ap[c], m_ah[c], m_am[c]);
            end else if (m_am[c] == 2) begin
               m_st[c] = 2; m_done[c] = 1;
            end else begin
               model_start(c);
            end
         end else begin
            m_done[c] = 1;
         end
      end
      ok = wr_en && (wr_period != 0) && (wr_mode != 3) && (int'(wr_ch) < CH);
      m_err = wr_en && !ok;
      if (ok) begin
         m_sp[wr_ch] = int'(wr_period); m_sh[wr_ch] = int'(wr_high); m_sm[wr_ch] = int'(wr_mode);
      end
   endtask

   task automatic compare_all(input string tag);
      logic [CH-1:0] e_div, e_tick, e_done;
      for (int c = 0; c < CH; c++) begin
         e_div[c] = m_div[c]; e_tick[c] = m_tick[c]; e_done[c] = m_done[c];
      end
      chk({tag, ".div"}, 64'(div_out), 64'(e_div));
      chk({tag, ".tick"}, 64'(tick), 64'(e_tick));
      chk({tag, ".done"}, 64'(done), 64'(e_done));
      chk({tag, ".err"}, 64'(wr_err), 64'(m_err));
   endtask

   task automatic step(input string tag, input logic we, input logic [1:0] ch,
                       input int per, input int high, input logic [1:0] mode);
      wr_en = we; wr_ch = ch; wr_period = W'(per); wr_high = W'(high); wr_mode = mode;
      @(posedge clk);
      if (!rst) model_reset();
      else      model_clock();
      #1;
      compare_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) step(tag, 1'b0, 2'd0, 0, 0, 2'd0);
   endtask

   logic [7:0] sq_exp = 8'b0011_0011;
   logic [5:0] os_exp = 6'b00_0011;

   initial begin
      model_reset();
      #12;
      compare_all("reset");
      #5 rst = 1'b1;

      step("sq_wr", 1'b1, 2'd0, 4, 0, 2'd0);
      ch_en = 3'b001;
      for (int k = 0; k < 8; k++) begin
         step("square", 1'b0, 2'd0, 0, 0, 2'd0);
         chk("sq_pat", 64'(div_out[0]), 64'(sq_exp[k]));
         chk("sq_tick", 64'(tick[0]), 64'((k % 4) == 0));
      end
      idle("sq_mid", 1);
      step("shadow_wr", 1'b1, 2'd0, 6, 0, 2'd0);
      idle("shadow", 16);

      step("rej_p0", 1'b1, 2'd0, 0, 1, 2'd0);
      chk("rej_p0_err", 64'(wr_err), 64'd1);
      step("rej_m3", 1'b1, 2'd0, 3, 1, 2'd3);
      chk("rej_m3_err", 64'(wr_err), 64'd1);
      step("rej_ch", 1'b1, 2'd3, 3, 1, 2'd0);
      idle("rej_after", 8);

      step("duty_wr", 1'b1, 2'd1, 5, 1, 2'd1);
      ch_en = 3'b011;
      idle("duty1", 11);
      step("duty_h0", 1'b1, 2'd1, 5, 0, 2'd1);
      idle("duty0", 11);
      step("duty_h7", 1'b1, 2'd1, 5, 7, 2'd1);
      idle("duty7", 11);
      chk("duty7_hi", 64'(div_out[1]), 64'd1);

      step("os_wr", 1'b1, 2'd2, 3, 2, 2'd2);
      for (int r = 0; r < 2; r++) begin
         ch_en[2] = 1'b1;
         for (int k = 0; k < 6; k++) begin
            step("oneshot", 1'b0, 2'd0, 0, 0, 2'd0);
            chk("os_pat", 64'(div_out[2]), 64'(os_exp[k]));
         end
         chk("os_done", 64'(done[2]), 64'd1);
         ch_en[2] = 1'b0;
         idle("os_off", 1);
      end

      step("p1_sq", 1'b1, 2'd0, 1, 0, 2'd0);
      step("p1_os", 1'b1, 2'd2, 1, 1, 2'd2);
      ch_en = 3'b111;
      idle("p1", 8);

      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 39) == 0) ch_en[c] = ~ch_en[c];
         if ($urandom_range(0, 3) == 0)
            step("rand", 1'b1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 10)), 2'($urandom_range(0, 3)));
         else
            idle("rand", 1);
      end

      ch_en = 3'b111;
      step("pre_rst_wr", 1'b1, 2'd0, 5, 2, 2'd1);
      idle("pre_rst", 3);
      #3 rst = 1'b0;
      #1;
      chk("arst_div", 64'(div_out), 64'd0);
      chk("arst_tick", 64'(tick), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      model_reset();
      idle("in_rst", 1);
      #2 rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         idle("def", 1);
         chk("def_sq", 64'(div_out), (k % 2 == 0) ? 64'h7 : 64'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/multi_ch_freq_div.md
Name: multi_ch_freq_div

Overview:
- Programmable multi-channel frequency divider for clk.
- Each channel generates a divided output with square, programmable-duty or one-shot waveform, plus a one-cycle tick at each period start.
- Configuration is written through a shared write port into per-channel shadow registers and takes effect only at a period boundary, so outputs never glitch.
- Sits beside the timer/divider logic and feeds timing strobes to the datapath and peripherals.

Parameters:
- CH, 4, number of independent channels (>=1).
- WIDTH, 32, bit width of period and high-time values.
- DEF_PERIOD, 2, reset value of every shadow/active period (must be >=1).
- DEF_HIGH, 1, reset value of every shadow/active high time.
- DEF_MODE, 0, reset value of every shadow/active mode.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ch_en  input  CH  per-channel run enable, level-sensitive.
- wr_en  input  1  config write strobe, one write per cycle.
- wr_ch  input  $clog2(CH) (min 1)  target channel.
- wr_period  input  WIDTH  period P in clk cycles.
- wr_high  input  WIDTH  high time H (duty mode only).
- wr_mode  input  2  0=square, 1=duty, 2=one-shot, 3=reserved.
- wr_err  output  1  one-cycle pulse: write rejected.
- div_out  output  CH  divided waveform.
- tick  output  CH  one-cycle pulse at phase 0 of each period.
- done  output  CH  one-shot completed.

Behaviour:
- Reset (async, rst=0):
  - cnt=0, active=0, div_out=0, tick=0, done=0, wr_err=0.
  - Shadow and active config = DEF_PERIOD/DEF_HIGH/DEF_MODE.
  - Reset mid-operation aborts all channels immediately.
- All outputs are registered.
- Config write (wr_en=1):
  - Rejected if wr_period==0, wr_mode==3, or wr_ch>=CH. Rejection means wr_err=1 next cycle and the shadow is unchanged.
  - Otherwise the shadow[wr_ch] is updated at that edge and wr_err=0.
  - The active config is copied from the shadow only on a load event (start or reload).
  - A write on the same edge as a load is not used by that load; it applies at the next boundary.
- Effective high time Heff:
  - square: ceil(P/2).
  - duty: min(H,P); H=0 gives constant low, H>=P gives constant high.
  - one-shot: min(H,P).
- Per-channel states, IDLE / RUN / DONE, evaluated each edge:
  - **ch_en=0:** go to IDLE. cnt=0, div_out=0, tick=0, done=0. This takes priority in every state.
  - **IDLE, ch_en=1 (start/load):** load active from shadow, cnt<=P-1, tick<=1, div_out<=(Heff>0), go to RUN. The first tick appears the cycle after ch_en is first sampled high.
  - **RUN, cnt!=0:** cnt<=cnt-1, tick<=0, div_out<=((P-cnt)<Heff), using the active config. The phase of the next cycle is P-cnt.
  - **RUN, cnt==0, mode!=one-shot (reload/load):** same actions as start, stays in RUN. Period is exactly P cycles; tick repeats every P cycles.
  - **RUN, cnt==0, one-shot:** go to DONE. div_out<=0, tick<=0, done<=1.
  - **DONE:** holds until ch_en=0; no reload. Re-arming requires ch_en low for >=1 cycle.
- P=1:
  - square/duty with Heff=1 gives div_out constant 1 and tick every cycle.
  - one-shot P=1 gives one high cycle, then DONE.
- Arithmetic:
  - Comparisons are unsigned WIDTH-bit.
  - ceil(P/2) is computed as (P>>1)+P[0]; there is no overflow for P=2^WIDTH-1.
- Channels are fully independent. A write to channel i never disturbs channel j.

Test Plan:
- **Square:** write ch0 P=4 mode0, ch_en[0]=1 → from the first cycle after enable, div_out[0]=1,1,0,0 repeating; tick[0] on every 4th cycle starting with the first.
- **Duty:** write ch1 P=5 H=1 mode1, enable → div_out[1]=1,0,0,0,0 repeating. Then H=0 gives constant 0; H=7 gives constant 1.
- **Shadow update:** ch0 running P=4; write P=6 mid-period → the current period completes at 4 cycles, the next tick arrives 4 cycles after the previous one, then the tick spacing is 6.
- **Rejects:** write wr_period=0, then wr_mode=3 → wr_err=1 for one cycle each; the waveform is unchanged.
- **One-shot:** ch2 P=3 H=2 mode2, enable → div_out=1,1,0, tick once, then done[2]=1 and stays. ch_en low then high restarts the sequence.
- **Reset:** rst=0 asynchronously mid-run → all outputs 0 immediately. After release with ch_en=1, each channel runs at DEF_PERIOD=2 (square: 1,0).
